// File: rtl/dsp_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_seq_pkg
// Description : Shared types and helpers for the DSP load sequencer.
//               Holds the sequencer state encoding, the toggle-rate ceiling
//               and the clamp helper applied to host-supplied rates.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_seq_pkg;

    // Highest meaningful toggle rate, in percent.
    localparam logic [6:0] TR_MAX = 7'd100;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COL_UP   = 3'd1,
        ST_DWELL    = 3'd2,
        ST_STEP     = 3'd3,
        ST_COL_DOWN = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    // Host registers are 7 bits wide and can hold up to 127; the array only
    // understands 0..100 percent.
    function automatic logic [6:0] clamp_tr(input logic [6:0] i_tr);
        return (i_tr > TR_MAX) ? TR_MAX : i_tr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : dsp_seq_timer
// Description : Loadable down-counter with a zero flag. Counts down to zero
//               and holds there; a load takes priority over counting.
// Ports       : clk, rst_n       - clock, async active-low reset
//               i_load           - load i_load_val on the next edge
//               i_load_val       - value loaded (cycles-1 until o_zero)
//               o_zero           - counter currently at zero
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_seq_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt_q;
    logic [WIDTH-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_load) begin
            w_cnt_d = i_load_val;
        end else if (r_cnt_q != '0) begin
            w_cnt_d = r_cnt_q - c_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_zero = (r_cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/dsp_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dsp_load_sequencer
// Description : Power-measurement run sequencer for the DSP load array.
//               Enables masked columns one by one, steps the shared toggle
//               rate from start to end level with a dwell per level, then
//               disables the columns in reverse order.
// Ports       : clk, rst_n          - clock, async active-low reset
//               start, abort        - run request / orderly shutdown
//               tr_start/end/step   - toggle-rate sweep configuration
//               dwell_cycles        - clocks per level (0 acts as 1)
//               col_mask            - participating columns
//               TOGGLE_RATE, col_en - registered drive to the DSP array
//               busy, done, err     - run status
//               sample_strobe       - logger strobe, last cycle of a dwell
//               step_idx            - current level index
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_load_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int NUM_DSP_COLUMN = 5,
    parameter int DWELL_W        = 32,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int STEP_IDX_W     = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [6:0]                tr_start,
    input  logic [6:0]                tr_end,
    input  logic [6:0]                tr_step,
    input  logic [DWELL_W-1:0]        dwell_cycles,
    input  logic [NUM_DSP_COLUMN-1:0] col_mask,
    output logic [6:0]                TOGGLE_RATE,
    output logic [NUM_DSP_COLUMN-1:0] col_en,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      sample_strobe,
    output logic [STEP_IDX_W-1:0]     step_idx
);

    // The timer reaches zero on the last cycle of an interval, so it is
    // loaded with the interval length minus one.
    localparam logic [DWELL_W-1:0]        c_SETTLE_LOAD = DWELL_W'(SETTLE_CYCLES - 1);
    localparam logic [DWELL_W-1:0]        c_DWELL_ONE   = DWELL_W'(1);
    localparam logic [NUM_DSP_COLUMN-1:0] c_COL_ONE     = NUM_DSP_COLUMN'(1);
    localparam logic [STEP_IDX_W-1:0]     c_IDX_ONE     = STEP_IDX_W'(1);

    state_e                      r_state_q,    w_state_d;
    logic [6:0]                  r_tr_q,       w_tr_d;
    logic [NUM_DSP_COLUMN-1:0]   r_col_en_q,   w_col_en_d;
    logic                        r_err_q,      w_err_d;
    logic [STEP_IDX_W-1:0]       r_step_idx_q, w_step_idx_d;
    logic [6:0]                  r_tr_end_q,   w_tr_end_d;
    logic [6:0]                  r_tr_step_q,  w_tr_step_d;
    logic [DWELL_W-1:0]          r_dwell_q,    w_dwell_d;
    logic [NUM_DSP_COLUMN-1:0]   r_mask_q,     w_mask_d;

    logic                        w_tmr_load;
    logic [DWELL_W-1:0]          w_tmr_val;
    logic                        w_tmr_zero;
    logic [6:0]                  w_tr_start_c;
    logic [6:0]                  w_tr_end_c;
    logic [7:0]                  w_next_tr;
    logic [NUM_DSP_COLUMN-1:0]   w_remaining;
    logic [NUM_DSP_COLUMN-1:0]   w_hi_bit;
    logic [DWELL_W-1:0]          w_dwell_load;

    dsp_seq_timer #(
        .WIDTH (DWELL_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    // Highest currently-enabled column, one-hot.
    always_comb begin
        w_hi_bit = '0;
        for (int i = 0; i < NUM_DSP_COLUMN; i++) begin
            if (r_col_en_q[i]) begin
                w_hi_bit    = '0;
                w_hi_bit[i] = 1'b1;
            end
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q    <= ST_IDLE;
            r_tr_q       <= '0;
            r_col_en_q   <= '0;
            r_err_q      <= 1'b0;
            r_step_idx_q <= '0;
            r_tr_end_q   <= '0;
            r_tr_step_q  <= '0;
            r_dwell_q    <= '0;
            r_mask_q     <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_tr_q       <= w_tr_d;
            r_col_en_q   <= w_col_en_d;
            r_err_q      <= w_err_d;
            r_step_idx_q <= w_step_idx_d;
            r_tr_end_q   <= w_tr_end_d;
            r_tr_step_q  <= w_tr_step_d;
            r_dwell_q    <= w_dwell_d;
            r_mask_q     <= w_mask_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_d    = r_state_q;
        w_tr_d       = r_tr_q;
        w_col_en_d   = r_col_en_q;
        w_err_d      = r_err_q;
        w_step_idx_d = r_step_idx_q;
        w_tr_end_d   = r_tr_end_q;
        w_tr_step_d  = r_tr_step_q;
        w_dwell_d    = r_dwell_q;
        w_mask_d     = r_mask_q;
        w_tmr_load   = 1'b0;
        w_tmr_val    = c_SETTLE_LOAD;

        w_tr_start_c = clamp_tr(tr_start);
        w_tr_end_c   = clamp_tr(tr_end);
        w_next_tr    = {1'b0, r_tr_q} + {1'b0, r_tr_step_q};
        w_remaining  = r_mask_q & ~r_col_en_q;
        w_dwell_load = (r_dwell_q == '0) ? '0 : (r_dwell_q - c_DWELL_ONE);

        unique case (r_state_q)
            ST_IDLE: begin
                // Abort held in IDLE suppresses a simultaneous start.
                if (start && !abort) begin
                    w_tr_end_d   = w_tr_end_c;
                    w_tr_step_d  = tr_step;
                    w_dwell_d    = dwell_cycles;
                    w_mask_d     = col_mask;
                    w_err_d      = 1'b0;
                    w_step_idx_d = '0;
                    if ((col_mask == '0) || (w_tr_start_c > w_tr_end_c)) begin
                        w_err_d   = 1'b1;
                        w_state_d = ST_DONE;
                    end else begin
                        // First (lowest) column comes up with the state change.
                        w_state_d  = ST_COL_UP;
                        w_tr_d     = w_tr_start_c;
                        w_col_en_d = col_mask & (~col_mask + c_COL_ONE);
                        w_tmr_load = 1'b1;
                    end
                end
            end
            ST_COL_UP, ST_DWELL, ST_STEP: begin
                if (abort) begin
                    w_state_d  = ST_COL_DOWN;
                    w_tr_d     = '0;
                    w_tmr_load = 1'b1;
                end else if (r_state_q == ST_COL_UP) begin
                    if (w_tmr_zero) begin
                        w_tmr_load = 1'b1;
                        if (w_remaining != '0) begin
                            w_col_en_d = r_col_en_q | (w_remaining & (~w_remaining + c_COL_ONE));
                        end else begin
                            w_state_d = ST_DWELL;
                            w_tmr_val = w_dwell_load;
                        end
                    end
                end else if (r_state_q == ST_DWELL) begin
                    if (w_tmr_zero) begin
                        w_state_d = ST_STEP;
                    end
                end else begin
                    w_tmr_load = 1'b1;
                    if ((r_tr_step_q == '0) || (w_next_tr > {1'b0, r_tr_end_q})) begin
                        w_state_d = ST_COL_DOWN;
                        w_tr_d    = '0;
                    end else begin
                        w_state_d = ST_DWELL;
                        w_tr_d    = w_next_tr[6:0];
                        w_tmr_val = w_dwell_load;
                        if (r_step_idx_q != {STEP_IDX_W{1'b1}}) begin
                            w_step_idx_d = r_step_idx_q + c_IDX_ONE;
                        end
                    end
                end
            end
            ST_COL_DOWN: begin
                if (r_col_en_q == '0) begin
                    w_state_d = ST_DONE;
                end else if (w_tmr_zero) begin
                    w_col_en_d = r_col_en_q & ~w_hi_bit;
                    w_tmr_load = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        busy          = (r_state_q != ST_IDLE);
        done          = (r_state_q == ST_DONE);
        sample_strobe = (r_state_q == ST_DWELL) && w_tmr_zero && !abort;
    end

    assign TOGGLE_RATE = r_tr_q;
    assign col_en      = r_col_en_q;
    assign err         = r_err_q;
    assign step_idx    = r_step_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_load_sequencer
// Description : Self-checking bench for dsp_load_sequencer. A phase-level
//               model expands each run into a per-cycle expected trace that
//               a single compare process checks against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_load_sequencer;

    localparam int NCOL   = 5;
    localparam int DW     = 32;
    localparam int SETTLE = 4;

    typedef struct {
        logic [6:0]      tr;
        logic [NCOL-1:0] col;
        logic            busy;
        logic            done;
        logic            strobe;
        logic            err;
        logic [6:0]      idx;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start, abort;
    logic [6:0]      tr_start, tr_end, tr_step;
    logic [DW-1:0]   dwell_cycles;
    logic [NCOL-1:0] col_mask;
    logic [6:0]      TOGGLE_RATE;
    logic [NCOL-1:0] col_en;
    logic            busy, done, err, sample_strobe;
    logic [6:0]      step_idx;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    exp_t cur;

    dsp_load_sequencer #(
        .NUM_DSP_COLUMN (NCOL),
        .DWELL_W        (DW),
        .SETTLE_CYCLES  (SETTLE),
        .STEP_IDX_W     (7)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .tr_start      (tr_start),
        .tr_end        (tr_end),
        .tr_step       (tr_step),
        .dwell_cycles  (dwell_cycles),
        .col_mask      (col_mask),
        .TOGGLE_RATE   (TOGGLE_RATE),
        .col_en        (col_en),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .sample_strobe (sample_strobe),
        .step_idx      (step_idx)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int tr, input logic [NCOL-1:0] col, input bit b,
                                input bit d, input bit s, input bit e, input int idx);
        exp_t v;
        v.tr = 7'(tr); v.col = col; v.busy = b; v.done = d;
        v.strobe = s; v.err = e; v.idx = 7'(idx);
        return v;
    endfunction

    // Expand one run into its cycle-by-cycle expected outputs, starting with
    // the cycle after start is sampled. abort_at < 0 means no abort.
    task automatic build_model(input int ts, input int te, input int tstep, input int dw,
                               input logic [NCOL-1:0] mask, input int abort_at);
        exp_t            t[$];
        logic [NCOL-1:0] col;
        int              tr, idx, nxt, d;
        bit              is_err;
        ts = (ts > 100) ? 100 : ts;
        te = (te > 100) ? 100 : te;
        is_err = (mask == '0) || (ts > te);
        if (is_err) begin
            exp_q.push_back(mk(0, '0, 1, 1, 0, 1, 0));
            exp_q.push_back(mk(0, '0, 0, 0, 0, 1, 0));
            return;
        end
        col = '0;
        idx = 0;
        for (int b = 0; b < NCOL; b++) begin
            if (mask[b]) begin
                col[b] = 1'b1;
                for (int c = 0; c < SETTLE; c++) t.push_back(mk(ts, col, 1, 0, 0, 0, 0));
            end
        end
        tr = ts;
        d  = (dw == 0) ? 1 : dw;
        while (1) begin
            for (int c = 0; c < d; c++) t.push_back(mk(tr, col, 1, 0, (c == d - 1), 0, idx));
            t.push_back(mk(tr, col, 1, 0, 0, 0, idx));
            nxt = tr + tstep;
            if (tstep == 0 || nxt > te) break;
            tr = nxt;
            if (idx < 127) idx++;
        end
        if (abort_at >= 0 && abort_at < t.size()) begin
            while (t.size() > abort_at + 1) void'(t.pop_back());
            t[abort_at].strobe = 1'b0;
            col = t[abort_at].col;
            idx = int'(t[abort_at].idx);
        end
        for (int b = NCOL - 1; b >= 0; b--) begin
            if (col[b]) begin
                for (int c = 0; c < SETTLE; c++) t.push_back(mk(0, col, 1, 0, 0, 0, idx));
                col[b] = 1'b0;
            end
        end
        t.push_back(mk(0, '0, 1, 0, 0, 0, idx));
        t.push_back(mk(0, '0, 1, 1, 0, 0, idx));
        t.push_back(mk(0, '0, 0, 0, 0, 0, idx));
        foreach (t[i]) exp_q.push_back(t[i]);
    endtask

    // Single compare process: one comparison per cycle while a trace is live.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            total++;
            if (TOGGLE_RATE !== cur.tr || col_en !== cur.col || busy !== cur.busy ||
                done !== cur.done || sample_strobe !== cur.strobe || err !== cur.err ||
                step_idx !== cur.idx) begin
                bad++;
                $display("FAIL cycle t=%0t got tr=%0d col=%b busy=%b done=%b strb=%b err=%b idx=%0d want tr=%0d col=%b busy=%b done=%b strb=%b err=%b idx=%0d",
                         $time, TOGGLE_RATE, col_en, busy, done, sample_strobe, err, step_idx,
                         cur.tr, cur.col, cur.busy, cur.done, cur.strobe, cur.err, cur.idx);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic do_start(input int ts, input int te, input int tstep, input int dw,
                            input logic [NCOL-1:0] mask, input int abort_at);
        @(posedge clk); #2;
        tr_start = 7'(ts); tr_end = 7'(te); tr_step = 7'(tstep);
        dwell_cycles = DW'(dw); col_mask = mask; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        build_model(ts, te, tstep, dw, mask, abort_at);
        if (abort_at >= 0) begin
            repeat (abort_at) @(posedge clk);
            #2 abort = 1'b1;
            @(posedge clk);
            #2 abort = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s timeout got=%0d left want=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int n_strb;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        tr_start = '0; tr_end = '0; tr_step = '0; dwell_cycles = '0; col_mask = '0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_tr", int'(TOGGLE_RATE), 0);
        check("reset_col", int'(col_en), 0);
        check("reset_busy_done_err_strb", int'({busy, done, err, sample_strobe}), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic run; pin the model trace with hand-computed values.
        do_start(20, 40, 10, 10, 5'b00101, -1);
        check("model_len", exp_q.size(), 52);
        check("model_col_first", int'(exp_q[0].col), 1);
        check("model_col_second", int'(exp_q[4].col), 5);
        check("model_strb0", int'({exp_q[17].strobe, exp_q[17].tr, exp_q[17].idx}), (1 << 14) | (20 << 7) | 0);
        check("model_strb1", int'({exp_q[28].strobe, exp_q[28].tr, exp_q[28].idx}), (1 << 14) | (30 << 7) | 1);
        check("model_strb2", int'({exp_q[39].strobe, exp_q[39].tr, exp_q[39].idx}), (1 << 14) | (40 << 7) | 2);
        check("model_down_tr", int'(exp_q[41].tr), 0);
        check("model_down_col", int'(exp_q[45].col), 1);
        check("model_done_idx", int'(exp_q[50].done), 1);
        n_strb = 0;
        foreach (exp_q[i]) n_strb += int'(exp_q[i].strobe);
        check("model_strobes", n_strb, 3);
        wait_drain("basic");

        // Clamp to 100 with a single level.
        do_start(120, 127, 0, 3, 5'b10000, -1);
        wait_drain("clamp");

        // Configuration errors.
        do_start(20, 40, 10, 5, 5'b00000, -1);
        wait_drain("err_mask");
        do_start(50, 30, 5, 5, 5'b00011, -1);
        wait_drain("err_order");

        // Start while busy is ignored; err from the previous run clears.
        do_start(20, 40, 10, 10, 5'b00101, -1);
        repeat (30) @(posedge clk);
        #2;
        tr_start = 7'd60; tr_end = 7'd70; tr_step = 7'd5; dwell_cycles = 32'd2;
        col_mask = 5'b01010; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_drain("busy_start");
        do_start(60, 70, 5, 2, 5'b01010, -1);
        wait_drain("new_cfg");

        // Abort in the second dwell.
        do_start(20, 40, 10, 10, 5'b00101, 22);
        wait_drain("abort");

        // Asynchronous reset in COL_UP.
        do_start(20, 40, 10, 10, 5'b00101, -1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_tr", int'(TOGGLE_RATE), 0);
        check("arst_col", int'(col_en), 0);
        check("arst_flags", int'({busy, done, err, sample_strobe}), 0);
        check("arst_idx", int'(step_idx), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        do_start(20, 40, 10, 10, 5'b00101, -1);
        wait_drain("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
